// File: rtl/la_ioringctrl.sv
// la_ioringctrl: IO ring power-on sequencer and serial configuration loader.
module la_ioringctrl #(
  parameter int RINGW  = 8,
  parameter int CFGW   = 16,
  parameter int NWORDS = 4,
  parameter int SETTLE = 64,
  parameter int CLKDIV = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic             shutdown,
  input  logic             cfg_valid,
  input  logic [CFGW-1:0]  cfg_data,
  output logic             cfg_ready,
  output logic             busy,
  output logic             done,
  output logic [RINGW-1:0] ioring
);
  localparam int CW = $clog2((SETTLE > CLKDIV ? SETTLE : CLKDIV) + 1);
  localparam int BW = $clog2(CFGW + 1);
  localparam int WW = $clog2(NWORDS + 1);
  typedef enum logic [2:0] {S_IDLE, S_ENABLE, S_LOAD, S_LATCH, S_RELEASE, S_DONE, S_OFF} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_bit;
  logic [WW-1:0]   r_word;
  logic [CFGW-1:0] r_shreg;
  logic            r_en, r_sclk, r_sdata, r_latch, r_iso, r_rdy, r_busy, r_done;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_word  <= '0;
      r_shreg <= '0;
      r_en    <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_latch <= 1'b0;
      r_iso   <= 1'b1;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (r_state != S_IDLE && r_state != S_OFF && shutdown) begin
      // isolate first; ring_en drops one cycle later in S_OFF
      r_state <= S_OFF;
      r_iso   <= 1'b1;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_latch <= 1'b0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_ENABLE;
          r_en    <= 1'b1;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
        S_ENABLE: if (r_cnt == CW'(SETTLE - 1)) begin
          r_state <= S_LOAD;
          r_rdy   <= 1'b1;
          r_word  <= '0;
        end else r_cnt <= r_cnt + 1'b1;
        S_LOAD: if (r_rdy) begin
          if (cfg_valid) begin
            r_rdy   <= 1'b0;
            r_sdata <= cfg_data[CFGW-1];
            r_shreg <= cfg_data << 1;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        end else if (r_cnt != CW'(CLKDIV - 1)) r_cnt <= r_cnt + 1'b1;
        else begin
          r_cnt  <= '0;
          r_sclk <= !r_sclk;
          // a bit ends when sclk returns low
          if (r_sclk) begin
            if (r_bit != BW'(CFGW - 1)) begin
              r_bit   <= r_bit + 1'b1;
              r_sdata <= r_shreg[CFGW-1];
              r_shreg <= r_shreg << 1;
            end else begin
              r_sdata <= 1'b0;
              if (r_word == WW'(NWORDS - 1)) begin
                r_state <= S_LATCH;
                r_latch <= 1'b1;
              end else begin
                r_word <= r_word + 1'b1;
                r_rdy  <= 1'b1;
              end
            end
          end
        end
        S_LATCH: if (r_cnt != CW'(CLKDIV - 1)) r_cnt <= r_cnt + 1'b1;
        else begin
          r_latch <= 1'b0;
          r_iso   <= 1'b0;
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        S_DONE: r_state <= S_DONE;
        S_OFF: begin
          r_en    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign cfg_ready = r_rdy;
  assign busy      = r_busy;
  assign done      = r_done;
  always_comb begin
    ioring      = '0;
    ioring[4:0] = {r_iso, r_latch, r_sdata, r_sclk, r_en};
  end
endmodule
